// File: rtl/ring_pkg.sv
// Shared encodings and seed helper for the parametrised ring/Johnson counter.
package ring_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  typedef enum logic {
    MODE_RING    = 1'b0,
    MODE_JOHNSON = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // Ring seeds with bit0 set; Johnson seeds with all zeros.
  function automatic logic [MAX_WIDTH-1:0] seed(input mode_e m, input int unsigned w);
    logic [MAX_WIDTH-1:0] s;
    s = '0;
    if (m == MODE_RING && w != 0) s[0] = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/ring_phase_decode.sv
// Combinational legality check and phase decode of a counter pattern.
module ring_phase_decode
  import ring_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned PW    = $clog2(2*WIDTH)
) (
  input  logic [WIDTH-1:0] i_pattern,
  input  logic             i_mode,
  output logic             o_legal,
  output logic [PW-1:0]    o_phase
);

  int unsigned      w_count;
  logic [PW-1:0]    w_idx;
  logic [WIDTH-1:0] w_lo_mask;
  logic [WIDTH-1:0] w_hi_mask;

  always_comb begin
    w_count   = 0;
    w_idx     = '0;
    w_lo_mask = '0;
    w_hi_mask = '0;
    o_legal   = 1'b0;
    o_phase   = '0;

    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i_pattern[i]) begin
        w_count = w_count + 1;
        w_idx   = PW'(i);
      end
    end

    // Reference runs of w_count ones anchored at either end of the register.
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_lo_mask[i] = (i < w_count);
      w_hi_mask[i] = (i >= WIDTH - w_count);
    end

    if (i_mode == MODE_RING) begin
      o_legal = (w_count == 1);
      o_phase = w_idx;
    end else if (i_pattern == w_lo_mask) begin
      o_legal = 1'b1;
      o_phase = PW'(w_count);
    end else if (i_pattern == w_hi_mask) begin
      o_legal = 1'b1;
      o_phase = PW'(2*WIDTH - w_count);
    end
  end

endmodule

// File: rtl/param_ring_counter.sv
// WIDTH-bit ring / Johnson counter with load, direction, phase and wrap.
// Optional RING_SELF_CORRECT_EN reseeds the counter from any illegal state.
module param_ring_counter
  import ring_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned PW    = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic [PW-1:0]    phase,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [PW-1:0] RING_LAST = PW'(WIDTH - 1);
  localparam logic [PW-1:0] JOHN_LAST = PW'(2*WIDTH - 1);

  mode_e            r_mode_q;
  logic [WIDTH-1:0] r_out;
  logic [PW-1:0]    r_phase;
  logic             r_wrap;
  logic             r_load_err;

  mode_e            w_mode_in;
  logic [WIDTH-1:0] w_seed_q;
  logic [WIDTH-1:0] w_seed_in;
  logic [WIDTH-1:0] w_step_out;
  logic [PW-1:0]    w_step_phase;
  logic [PW-1:0]    w_last;
  logic             w_load_legal;
  logic [PW-1:0]    w_load_phase;

  assign w_mode_in = mode_e'(mode);
  assign w_seed_q  = WIDTH'(seed(r_mode_q, WIDTH));
  assign w_seed_in = WIDTH'(seed(w_mode_in, WIDTH));
  assign w_last    = (r_mode_q == MODE_RING) ? RING_LAST : JOHN_LAST;

  ring_phase_decode #(.WIDTH(WIDTH), .PW(PW)) u_load_decode (
    .i_pattern (load_val),
    .i_mode    (mode),
    .o_legal   (w_load_legal),
    .o_phase   (w_load_phase)
  );

`ifdef RING_SELF_CORRECT_EN
  logic w_cur_legal;

  ring_phase_decode #(.WIDTH(WIDTH), .PW(PW)) u_state_decode (
    .i_pattern (r_out),
    .i_mode    (r_mode_q),
    .o_legal   (w_cur_legal),
    .o_phase   ()
  );
`endif

  always_comb begin
    w_step_out   = r_out;
    w_step_phase = r_phase;
    if (dir == DIR_LEFT) begin
      if (r_mode_q == MODE_RING) w_step_out = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
      else                       w_step_out = {r_out[WIDTH-2:0], ~r_out[WIDTH-1]};
      w_step_phase = (r_phase == w_last) ? '0 : r_phase + PW'(1);
    end else begin
      if (r_mode_q == MODE_RING) w_step_out = {r_out[0], r_out[WIDTH-1:1]};
      else                       w_step_out = {~r_out[0], r_out[WIDTH-1:1]};
      w_step_phase = (r_phase == '0) ? w_last : r_phase - PW'(1);
    end
  end

  // wrap and load_err are single-cycle pulses: cleared on every edge unless re-raised.
  always_ff @(posedge clk) begin
    r_wrap     <= 1'b0;
    r_load_err <= 1'b0;
    if (!reset) begin
      r_mode_q <= w_mode_in;
      r_out    <= w_seed_in;
      r_phase  <= '0;
    end
`ifdef RING_SELF_CORRECT_EN
    else if (!w_cur_legal) begin
      r_out   <= w_seed_q;
      r_phase <= '0;
    end
`endif
    else if (load) begin
      if (w_load_legal) begin
        r_out    <= load_val;
        r_phase  <= w_load_phase;
        r_mode_q <= w_mode_in;
      end else begin
        r_load_err <= 1'b1;
      end
    end else if (w_mode_in != r_mode_q) begin
      r_mode_q <= w_mode_in;
      r_out    <= w_seed_in;
      r_phase  <= '0;
    end else if (en) begin
      r_out   <= w_step_out;
      r_phase <= w_step_phase;
      r_wrap  <= (w_step_out == w_seed_q);
    end
  end

  assign out      = r_out;
  assign phase    = r_phase;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_param_ring_counter.sv
// Directed bench for param_ring_counter (WIDTH=4), both macro builds.
module tb_param_ring_counter;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned PW    = $clog2(2*WIDTH);

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             mode;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic [PW-1:0]    phase;
  logic             wrap;
  logic             load_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  param_ring_counter #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .out      (out),
    .phase    (phase),
    .wrap     (wrap),
    .load_err (load_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_state(input string tag, input logic [3:0] e_out, input logic [2:0] e_phase,
                              input logic e_wrap, input logic e_err);
    check_eq({tag, ".out"},      32'(out),      32'(e_out));
    check_eq({tag, ".phase"},    32'(phase),    32'(e_phase));
    check_eq({tag, ".wrap"},     32'(wrap),     32'(e_wrap));
    check_eq({tag, ".load_err"}, 32'(load_err), 32'(e_err));
  endtask

  task automatic do_reset(input logic m);
    reset = 1'b0; mode = m; load = 1'b0; en = 1'b1; dir = 1'b0;
    tick;
    reset = 1'b1;
  endtask

  logic [3:0] ring_l_out [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [2:0] ring_l_ph  [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
  logic [3:0] john_out   [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                 4'b1110, 4'b1100, 4'b1000, 4'b0000};
  logic [3:0] jload_val  [4] = '{4'b0111, 4'b1111, 4'b0000, 4'b1000};
  logic [2:0] jload_ph   [4] = '{3'd3, 3'd4, 3'd0, 3'd7};

  initial begin
    reset = 1'b0; en = 1'b1; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;

    // Ring, left, from reset held for two clocks
    tick; tick;
    expect_state("rst_ring", 4'b0001, 3'd0, 1'b0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      expect_state($sformatf("ring_l%0d", i), ring_l_out[i], ring_l_ph[i], i == 3, 1'b0);
    end

    // Johnson, left, full period of 8
    do_reset(1'b1);
    expect_state("rst_john", 4'b0000, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick;
      expect_state($sformatf("john_l%0d", i), john_out[i], 3'(i + 1), i == 7, 1'b0);
    end

    // Ring right, hold, reverse
    do_reset(1'b0);
    dir = 1'b1;
    tick; expect_state("ring_r0", 4'b1000, 3'd3, 1'b0, 1'b0);
    tick; expect_state("ring_r1", 4'b0100, 3'd2, 1'b0, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick; expect_state($sformatf("hold%0d", i), 4'b0100, 3'd2, 1'b0, 1'b0);
    end
    en = 1'b1; dir = 1'b0;
    tick; expect_state("ring_flip", 4'b1000, 3'd3, 1'b0, 1'b0);
    dir = 1'b1;
    tick; expect_state("ring_r2", 4'b0100, 3'd2, 1'b0, 1'b0);
    tick; expect_state("ring_r3", 4'b0010, 3'd1, 1'b0, 1'b0);
    tick; expect_state("ring_rwrap", 4'b0001, 3'd0, 1'b1, 1'b0);

    // Loads
    do_reset(1'b1);
    load = 1'b1; load_val = 4'b1100;
    tick; expect_state("jload_1100", 4'b1100, 3'd6, 1'b0, 1'b0);
    load_val = 4'b0101;
    tick; expect_state("jload_bad", 4'b1100, 3'd6, 1'b0, 1'b1);
    load = 1'b0; en = 1'b0;
    tick; expect_state("jload_errclr", 4'b1100, 3'd6, 1'b0, 1'b0);
    load = 1'b1; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load_val = jload_val[i];
      tick; expect_state($sformatf("jload%0d", i), jload_val[i], jload_ph[i], 1'b0, 1'b0);
    end
    mode = 1'b0; load_val = 4'b0110;
    tick; expect_state("rload_bad", 4'b1000, 3'd7, 1'b0, 1'b1);
    load_val = 4'b0100;
    tick; expect_state("rload_0100", 4'b0100, 3'd2, 1'b0, 1'b0);
    load = 1'b0;
    tick; expect_state("rload_step", 4'b1000, 3'd3, 1'b0, 1'b0);
    load = 1'b1; load_val = 4'b0001;
    tick; expect_state("rload_seed", 4'b0001, 3'd0, 1'b0, 1'b0);
    load = 1'b0;
    tick; expect_state("ring_step2", 4'b0010, 3'd1, 1'b0, 1'b0);

    // Mode change mid-sequence and reset priority
    mode = 1'b1;
    tick; expect_state("mode_to_j", 4'b0000, 3'd0, 1'b0, 1'b0);
    tick; expect_state("mode_j_step", 4'b0001, 3'd1, 1'b0, 1'b0);
    mode = 1'b0;
    tick; expect_state("mode_to_r", 4'b0001, 3'd0, 1'b0, 1'b0);
    tick; expect_state("mode_r_step", 4'b0010, 3'd1, 1'b0, 1'b0);
    reset = 1'b0; load = 1'b1; load_val = 4'b0100;
    tick; expect_state("rst_vs_load", 4'b0001, 3'd0, 1'b0, 1'b0);
    mode = 1'b1; load_val = 4'b0011;
    tick; expect_state("rst_vs_loadj", 4'b0000, 3'd0, 1'b0, 1'b0);

    // Illegal state injection
    do_reset(1'b0);
    force dut.r_out = 4'b1010;
    #1;
    release dut.r_out;
    tick;
`ifdef RING_SELF_CORRECT_EN
    expect_state("self_correct", 4'b0001, 3'd0, 1'b0, 1'b0);
`else
    check_eq("illegal_rot.out", 32'(out), 32'(4'b0101));
    check_eq("illegal_rot.wrap", 32'(wrap), 32'(1'b0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/param_ring_counter.md
Name: param_ring_counter

Overview:
- Parametrised successor to the fixed 4-bit ring counter.
- WIDTH-bit shift-register counter with two run-time modes:
  - ring: one-hot rotate, period WIDTH.
  - Johnson: twisted ring, period 2*WIDTH.
- Also provides direction control, clock enable, validated parallel load, a phase index and a wrap pulse.
- Used as a sequencer/one-hot phase generator feeding downstream mux selects and scan strobes.

Parameters:
- WIDTH, 4, register width; legal range 2..32.
- PW, $clog2(2*WIDTH), width of the phase output (derived; not to be overridden).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- en  in  1  step enable.
- mode  in  1  0 = ring, 1 = Johnson.
- dir  in  1  0 = shift left (toward MSB), 1 = shift right.
- load  in  1  parallel-load request.
- load_val  in  WIDTH  value to load.
- out  out  WIDTH  counter state.
- phase  out  PW  position in sequence, 0 = seed.
- wrap  out  1  one-cycle flag: step has returned out to seed.
- load_err  out  1  one-cycle flag: load rejected as illegal for current mode.

Behaviour:
- Seeds:
  - Ring seed = 1 (bit0 set, others 0).
  - Johnson seed = all zeros.
- Reset (reset==0 at clock edge):
  - mode_q <= mode.
  - out <= seed(mode); phase <= 0.
  - wrap <= 0; load_err <= 0.
- Priority each edge, when out of reset: load > mode change (mode != mode_q) > en step > hold.
- Step rules (W = WIDTH):
  - Ring left: out <= {out[W-2:0], out[W-1]}.
  - Ring right: out <= {out[0], out[W-1:1]}.
  - Johnson left: out <= {out[W-2:0], ~out[W-1]}.
  - Johnson right: out <= {~out[0], out[W-1:1]}.
- Phase tracking:
  - Left step: phase +1 modulo period.
  - Right step: phase -1 modulo period.
  - Period = W (ring) or 2W (Johnson). Phase 0 <-> period-1 wraps both ways.
- wrap:
  - Registered alongside out.
  - 1 only in the cycle after an en step lands out on the seed, in either direction.
  - 0 after reset, load, reseed or hold, even if out equals the seed.
- Mode change:
  - mode_q <= mode; out <= seed(new mode); phase <= 0; wrap <= 0.
  - en is ignored in that cycle.
- Load:
  - load_val is decoded for legality under the currently sampled mode input.
    - Ring: legal iff exactly one bit set.
    - Johnson: legal iff a contiguous run of ones anchored at bit0, or a contiguous run anchored at bit W-1, or all zeros.
  - Legal load: out <= load_val; phase <= decoded phase; mode_q <= mode; load_err <= 0.
  - Illegal load: out, phase and mode_q hold; load_err <= 1 for one cycle.
  - en is ignored in any load cycle.
- Johnson phase decode (k = popcount):
  - Low-anchored run: phase = k.
  - High-anchored run with 0 < k < W: phase = 2W-k.
  - All ones: phase = W; all zeros: phase = 0.
- Reset asserted mid-sequence overrides every other input in that cycle.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: RING_SELF_CORRECT_EN.
- Defined:
  - Each cycle, out is checked for legality against mode_q.
  - If illegal (e.g. upset or forced value), the next edge reseeds: out <= seed(mode_q), phase <= 0, wrap <= 0.
  - Priority is below reset, above load.
- Undefined: no check. An illegal state propagates per the step rules and phase is not corrected.

Decomposition:
- Shared package ring_pkg:
  - Mode encodings MODE_RING = 1'b0, MODE_JOHNSON = 1'b1.
  - Direction encodings DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1.
  - Seed function seed(mode, W).
- One sub-module, ring_phase_decode:
  - Combinational.
  - Inputs: pattern, mode. Outputs: legal, phase.
  - Reused for load validation and for the RING_SELF_CORRECT_EN check.

Test Plan:
1. WIDTH=4, reset=0 for 2 clocks then 1, mode=0, dir=0, en=1 -> out 0001 at reset, then 0010, 0100, 1000, 0001. wrap=1 only with the final 0001; phase 0,1,2,3,0.
2. mode=1, dir=0, en=1 from reset -> out 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000. wrap on the 9th value; phase reaches 7, then 0.
3. Ring, dir=1 from seed -> 1000 (phase 3), 0100 (phase 2); en=0 for 3 cycles holds 0100; flip dir=0 -> 1000.
4. Johnson, load=1, load_val=1100 -> out 1100, phase 6, load_err 0. load_val=0101 -> out held, load_err=1 for one cycle. Ring load 0110 -> rejected.
5. Toggle mode mid-sequence with en=1 -> next out = new seed, phase 0, wrap 0. Assert reset together with load=1 -> reset wins, out = seed.
6. With RING_SELF_CORRECT_EN: force out=1010 in ring mode for one cycle, then release -> next edge out=0001, phase 0. Without the macro: 1010 rotates to 0101.
